// File: rtl/set_assoc_cache_memory.sv
// N-way set-associative line store: per-way tag/valid/data, round-robin victim,
// sequential whole-cache invalidate, registered fetch result with request passthrough.

module set_assoc_cache_way #(
  parameter int TAG_W   = 51,
  parameter int INDEX_W = 8,
  parameter int LINE_W  = 256
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic [0:INDEX_W-1] rd_index,
  input  logic [0:TAG_W-1]   rd_tag,
  output logic               rd_hit,
  output logic [0:LINE_W-1]  rd_line,
  input  logic               wr_en,
  input  logic [0:INDEX_W-1] wr_index,
  input  logic [0:TAG_W-1]   wr_tag,
  input  logic [0:LINE_W-1]  wr_line,
  output logic               wr_valid,
  output logic               wr_match,
  input  logic               clr_en,
  input  logic [0:INDEX_W-1] clr_index
);
  localparam int SETS = 1 << INDEX_W;

  logic [SETS-1:0]   valid;
  logic [0:TAG_W-1]  tag_mem  [SETS];
  logic [0:LINE_W-1] data_mem [SETS];

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i)    valid <= '0;
    else if (clr_en) valid[clr_index] <= 1'b0;
    else if (wr_en)  valid[wr_index] <= 1'b1;
  end

  // storage is left uninitialised; valid bits alone gate every use
  always_ff @(posedge clock_i) begin
    if (wr_en) begin
      tag_mem[wr_index]  <= wr_tag;
      data_mem[wr_index] <= wr_line;
    end
  end

  // combinational reads see pre-write contents within the cycle
  assign rd_hit   = valid[rd_index] && (tag_mem[rd_index] == rd_tag);
  assign rd_line  = data_mem[rd_index];
  assign wr_valid = valid[wr_index];
  assign wr_match = wr_valid && (tag_mem[wr_index] == wr_tag);
endmodule

module set_assoc_cache_memory #(
  parameter int TAG_W    = 51,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 5,
  parameter int LINE_W   = 256,
  parameter int WAYS     = 2
) (
  input  logic                clock_i,
  input  logic                reset_i,
  input  logic                fetchEnable_i,
  input  logic [0:TAG_W-1]    tag_i,
  input  logic [0:INDEX_W-1]  index_i,
  input  logic [0:OFFSET_W-1] offset_i,
  input  logic                updateEnable_i,
  input  logic [0:LINE_W-1]   newCacheline_i,
  input  logic [0:TAG_W-1]    newTag_i,
  input  logic [0:INDEX_W-1]  newIndex_i,
  input  logic                flush_i,
  output logic [0:TAG_W-1]    tag_o,
  output logic [0:INDEX_W-1]  index_o,
  output logic [0:OFFSET_W-1] offset_o,
  output logic [0:LINE_W-1]   cacheline_o,
  output logic                hit_o,
  output logic                enable_o,
  output logic                busy_o
);
  localparam int SETS  = 1 << INDEX_W;
  localparam int PTR_W = (WAYS > 1) ? $clog2(WAYS) : 1;

  typedef enum logic {IDLE, FLUSH} state_t;

  state_t                       state, state_nxt;
  logic [INDEX_W-1:0]           flush_cnt, flush_cnt_nxt;
  logic                         fetch_go, upd_go, flush_clr, use_rr;
  logic [WAYS-1:0]              rd_hit, wr_valid, wr_match, wr_sel;
  logic [WAYS-1:0][0:LINE_W-1]  rd_line;
  logic [0:LINE_W-1]            hit_line;
  logic [PTR_W-1:0]             sel_way, rr_cur;

  assign fetch_go  = fetchEnable_i && (state == IDLE);
  assign upd_go    = updateEnable_i && (state == IDLE);
  assign flush_clr = (state == FLUSH);
  assign busy_o    = (state == FLUSH);

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      state     <= IDLE;
      flush_cnt <= '0;
    end else begin
      state     <= state_nxt;
      flush_cnt <= flush_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    flush_cnt_nxt = flush_cnt;
    case (state)
      IDLE: if (flush_i) begin
        state_nxt     = FLUSH;
        flush_cnt_nxt = '0;
      end
      FLUSH: begin
        flush_cnt_nxt = flush_cnt + INDEX_W'(1);
        if (&flush_cnt) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // victim: matching way, else lowest invalid way, else round-robin pointer
  always_comb begin
    sel_way = '0;
    use_rr  = 1'b1;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!wr_valid[w]) begin sel_way = PTR_W'(w); use_rr = 1'b0; end
    for (int w = WAYS - 1; w >= 0; w--)
      if (wr_match[w]) begin sel_way = PTR_W'(w); use_rr = 1'b0; end
    if (use_rr) sel_way = rr_cur;
  end

  if (WAYS > 1) begin : g_rr
    logic [SETS-1:0][PTR_W-1:0] rr_ptr;
    assign rr_cur = rr_ptr[newIndex_i];
    always_ff @(posedge clock_i or negedge reset_i) begin
      if (!reset_i) rr_ptr <= '0;
      else if (upd_go && use_rr)
        rr_ptr[newIndex_i] <= (rr_cur == PTR_W'(WAYS - 1)) ? '0 : rr_cur + PTR_W'(1);
    end
  end else begin : g_no_rr
    assign rr_cur = '0;
  end

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    assign wr_sel[w] = upd_go && (sel_way == PTR_W'(w));
    set_assoc_cache_way #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .LINE_W(LINE_W)) u_way (
      .clock_i  (clock_i),
      .reset_i  (reset_i),
      .rd_index (index_i),
      .rd_tag   (tag_i),
      .rd_hit   (rd_hit[w]),
      .rd_line  (rd_line[w]),
      .wr_en    (wr_sel[w]),
      .wr_index (newIndex_i),
      .wr_tag   (newTag_i),
      .wr_line  (newCacheline_i),
      .wr_valid (wr_valid[w]),
      .wr_match (wr_match[w]),
      .clr_en   (flush_clr),
      .clr_index(flush_cnt)
    );
  end

  always_comb begin
    hit_line = '0;
    for (int w = 0; w < WAYS; w++)
      if (rd_hit[w]) hit_line = hit_line | rd_line[w];
  end

  always_ff @(posedge clock_i or negedge reset_i) begin
    if (!reset_i) begin
      enable_o    <= 1'b0;
      hit_o       <= 1'b0;
      cacheline_o <= '0;
      tag_o       <= '0;
      index_o     <= '0;
      offset_o    <= '0;
    end else begin
      enable_o <= fetch_go;
      if (fetch_go) begin
        hit_o       <= |rd_hit;
        cacheline_o <= hit_line;
        tag_o       <= tag_i;
        index_o     <= index_i;
        offset_o    <= offset_i;
      end
    end
  end
endmodule

// File: tb/tb_set_assoc_cache_memory.sv
// Scoreboard bench: fetch expectations queued at drive time, checked when the result is due.
module tb_set_assoc_cache_memory;
  logic         clock_i = 1'b0, reset_i = 1'b0;
  logic         fetchEnable_i = 1'b0, updateEnable_i = 1'b0, flush_i = 1'b0;
  logic [0:50]  tag_i = '0, newTag_i = '0, tag_o;
  logic [0:7]   index_i = '0, newIndex_i = '0, index_o;
  logic [0:4]   offset_i = '0, offset_o;
  logic [0:255] newCacheline_i = '0, cacheline_o;
  logic         hit_o, enable_o, busy_o;

  set_assoc_cache_memory dut (
    .clock_i(clock_i), .reset_i(reset_i), .fetchEnable_i(fetchEnable_i),
    .tag_i(tag_i), .index_i(index_i), .offset_i(offset_i),
    .updateEnable_i(updateEnable_i), .newCacheline_i(newCacheline_i),
    .newTag_i(newTag_i), .newIndex_i(newIndex_i), .flush_i(flush_i),
    .tag_o(tag_o), .index_o(index_o), .offset_o(offset_o),
    .cacheline_o(cacheline_o), .hit_o(hit_o), .enable_o(enable_o), .busy_o(busy_o)
  );

  always #5 clock_i = ~clock_i;

  typedef struct {
    int           due;
    bit           en;
    bit           hit;
    logic [0:255] line;
    logic [0:50]  tag;
    logic [0:7]   idx;
    logic [0:4]   off;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0, n_chk = 0, n_err = 0;

  localparam logic [0:255] L2 = 256'hFFFFFFFF_EEEEEEEE_DDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA_99999999_88888888;
  localparam logic [0:255] LA = {32{8'hAA}};
  localparam logic [0:255] LB = {32{8'h55}};
  localparam logic [0:255] LC = {32{8'hC3}};

  always @(posedge clock_i) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [0:255] tline(input int t);
    logic [0:255] l;
    l = {8{32'h1000_0000 + 32'(t)}};
    return l;
  endfunction

  task automatic step();
    @(negedge clock_i);
    fetchEnable_i = 1'b0; updateEnable_i = 1'b0; flush_i = 1'b0;
  endtask

  task automatic fetch_req(input int t, input int i, input int o, input bit en, input bit h,
                           input logic [0:255] l);
    exp_t e;
    fetchEnable_i = 1'b1; tag_i = 51'(t); index_i = 8'(i); offset_i = 5'(o);
    e.due = cyc + 1; e.en = en; e.hit = h; e.line = h ? l : '0;
    e.tag = 51'(t); e.idx = 8'(i); e.off = 5'(o);
    exp_q.push_back(e);
  endtask

  task automatic fill_req(input int t, input int i, input logic [0:255] l);
    updateEnable_i = 1'b1; newTag_i = 51'(t); newIndex_i = 8'(i); newCacheline_i = l;
  endtask

  always @(negedge clock_i) begin
    exp_t e;
    if (reset_i) begin
      if (exp_q.size() != 0 && exp_q[0].due == cyc) begin
        e = exp_q.pop_front();
        chk("enable", 256'(enable_o), 256'(e.en));
        if (e.en) begin
          chk("hit", 256'(hit_o), 256'(e.hit));
          chk("line", cacheline_o, e.line);
          chk("tag_o", 256'(tag_o), 256'(e.tag));
          chk("index_o", 256'(index_o), 256'(e.idx));
          chk("offset_o", 256'(offset_o), 256'(e.off));
        end
      end else begin
        chk("idle_enable", 256'(enable_o), 256'(0));
      end
    end
  end

  initial begin
    #200_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_busy"}, 256'(busy_o), 256'(0));
    chk({tag, "_enable"}, 256'(enable_o), 256'(0));
    chk({tag, "_hit"}, 256'(hit_o), 256'(0));
    chk({tag, "_line"}, cacheline_o, 256'(0));
    chk({tag, "_tag"}, 256'(tag_o), 256'(0));
    chk({tag, "_index"}, 256'(index_o), 256'(0));
    chk({tag, "_offset"}, 256'(offset_o), 256'(0));
  endtask

  initial begin
    int n;
    repeat (3) @(negedge clock_i);
    chk_outputs_zero("reset");
    reset_i = 1'b1;

    // 1: cold miss
    step(); fetch_req(55, 0, 0, 1, 0, '0);
    // 2: fill then hit, different tag misses
    step(); fill_req(55, 0, L2);
    step(); fetch_req(55, 0, 7, 1, 1, L2);
    step(); fetch_req(56, 0, 3, 1, 0, '0);
    // 3: round-robin eviction in set 1
    step(); fill_req(10, 1, tline(10));
    step(); fill_req(20, 1, tline(20));
    step(); fill_req(30, 1, tline(30));
    step(); fetch_req(20, 1, 0, 1, 1, tline(20));
    step(); fetch_req(30, 1, 0, 1, 1, tline(30));
    step(); fetch_req(10, 1, 0, 1, 0, '0);
    step(); fill_req(40, 1, tline(40));
    step(); fetch_req(20, 1, 0, 1, 0, '0);
    step(); fetch_req(40, 1, 0, 1, 1, tline(40));
    step(); fetch_req(30, 1, 0, 1, 1, tline(30));
    // 4: read-before-write and same-tag overwrite in place
    step(); fill_req(5, 3, LA); fetch_req(5, 3, 1, 1, 0, '0);
    step(); fill_req(5, 3, LB); fetch_req(5, 3, 2, 1, 1, LA);
    step(); fetch_req(5, 3, 4, 1, 1, LB);
    step(); fill_req(6, 3, LC);
    step(); fetch_req(5, 3, 0, 1, 1, LB);
    step(); fetch_req(6, 3, 0, 1, 1, LC);

    // 5: flush timing, fetch coinciding with flush pulse still served
    step(); fill_req(77, 255, tline(77));
    step(); fetch_req(55, 0, 9, 1, 1, L2); flush_i = 1'b1;
    step();
    n = 0;
    while (busy_o && n < 400) begin
      n++;
      if (n == 5) fetch_req(77, 255, 0, 0, 0, '0);
      if (n == 10) begin fill_req(88, 7, tline(88)); flush_i = 1'b1; end
      step();
    end
    chk("busy_len", 256'(n), 256'(256));
    fetch_req(55, 0, 0, 1, 0, '0);
    step(); fetch_req(77, 255, 0, 1, 0, '0);
    step(); fetch_req(88, 7, 0, 1, 0, '0);
    step(); chk("busy_after", 256'(busy_o), 256'(0));

    // 6: reset in the middle of a flush
    fill_req(99, 9, tline(99));
    step(); fill_req(55, 0, L2);
    step(); fetch_req(99, 9, 6, 1, 1, tline(99));
    step(); flush_i = 1'b1;
    step(); chk("busy_start", 256'(busy_o), 256'(1));
    repeat (100) step();
    #2 reset_i = 1'b0;
    #1 chk_outputs_zero("midflush_reset");
    step(); step();
    reset_i = 1'b1;
    step(); chk("busy_post_reset", 256'(busy_o), 256'(0));
    fetch_req(99, 9, 0, 1, 0, '0);
    step(); fetch_req(55, 0, 0, 1, 0, '0);
    step(); step(); step();
    chk("queue_drained", 256'(exp_q.size()), 256'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
